periph_bus_ctrl: RTL and testbench
==================================

// Module: periph_bus_ctrl
// PURPOSE
//  Sequences single CPU load/store transactions onto the peripheral bus. Decodes the
//  CPU address against four aligned 2^n regions (base/mask match), drives a one-hot select
//  to the matching peripheral, and waits for that peripheral's ack. It then returns read
//  data plus a one-cycle done/err to the CPU. Sits between the LEGv8 core's data port and
//  the peripheral slaves.
// PARAMETERS
//  BASE0 / MASK0   32'h20000000 / 32'hFFFF0000  region 0 base / care-mask (1 = compared bit)
//  BASE1 / MASK1   32'h20010000 / 32'hFFFF0000  region 1
//  BASE2 / MASK2   32'h20020000 / 32'hFFFF0000  region 2
//  BASE3 / MASK3   32'h20030000 / 32'hFFFF0000  region 3
//  TIMEOUT_CYCLES  16   max cycles SEL may wait for ack (used only with PBC_TIMEOUT_EN)
// PORTS
//  clk            in   1    clock, all state on rising edge
//  reset_n        in   1    asynchronous reset, active-low
//  cpu_req        in   1    transaction request; sampled only in IDLE
//  cpu_we         in   1    1 = write, 0 = read
//  cpu_addr       in   32   byte address; CPU holds stable until cpu_done
//  cpu_wdata      in   64   write data
//  cpu_rdata      out  64   read data, valid in the cycle cpu_done=1
//  cpu_done       out  1    one-cycle completion pulse
//  cpu_err        out  1    with cpu_done: unmapped address or timeout
//  per_sel        out  4    one-hot peripheral select, held until ack
//  per_we         out  1    registered copy of cpu_we
//  per_addr       out  32   registered copy of cpu_addr
//  per_wdata      out  64   registered copy of cpu_wdata
//  per_rdata      in   256  {rdata3,rdata2,rdata1,rdata0}, 64 b each
//  per_ack        in   4    per-peripheral ack, one bit per region
// BEHAVIOUR
//  - Reset (reset_n=0, any time, incl. mid-transaction):
//    - state=IDLE; per_sel=0, per_we=0, per_addr=0, per_wdata=0.
//    - cpu_rdata=0, cpu_done=0, cpu_err=0; timeout counter=0. No pending work survives.
//  - Region i hits when (cpu_addr & MASKi) == BASEi. Overlapping hits: lowest index wins.
//  - FSM IDLE -> ACCESS -> RESP -> IDLE:
//    - IDLE, cpu_req=1, hit region i:
//      - latch we/addr/wdata; next cycle per_sel = 1<<i; state=ACCESS.
//    - IDLE, cpu_req=1, no hit:
//      - per_sel stays 0; state=RESP with err=1, rdata=0.
//    - ACCESS:
//      - hold per_sel/per_we/per_addr/per_wdata.
//      - On per_ack[i]=1 for the selected i: capture rdata i (0 on writes), drop per_sel
//        next cycle, state=RESP.
//      - per_ack bits for unselected regions are ignored.
//    - RESP: cpu_done=1 for exactly one cycle with cpu_rdata/cpu_err; state=IDLE.
//  - cpu_req during ACCESS/RESP is ignored.
//    - A req held high through RESP is re-sampled in the following IDLE cycle, so
//      back-to-back transactions are spaced by one IDLE cycle.
//  - Latency, hit: req@T0 -> per_sel@T1 -> ack@Tk (k>=1) -> cpu_done@Tk+1.
//    Zero-wait slave: done@T2.
//  - Latency, unmapped: req@T0 -> done+err@T1.
//  - cpu_rdata holds its last value outside RESP. cpu_err is 0 whenever cpu_done is 0.
// CONFIGURATION
//  PBC_TIMEOUT_EN defined:
//    - 5-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
//    - Reaching TIMEOUT_CYCLES with no ack: drop per_sel, go to RESP with err=1, rdata=0.
//    - Ack in the same cycle the limit is reached: ack wins (no error).
//  PBC_TIMEOUT_EN undefined:
//    - no counter; ACCESS waits indefinitely for ack.
// TESTING
//  1. Reset release, no req -> all outputs 0 for 10 cycles; assert reset_n=0 mid-ACCESS ->
//     per_sel=0 asynchronously, FSM back in IDLE.
//  2. Read 0x20010008, slave 1 acks at T1 with 64'hDEADBEEF_00000001 -> per_sel=4'b0010 @T1;
//     done@T2, rdata=64'hDEADBEEF_00000001, err=0.
//  3. Write 0x20030000, wdata=64'h55, ack after 3 wait cycles -> per_sel=4'b1000,
//     per_we=1, per_wdata=64'h55 held 4 cycles; done 1 cycle, err=0.
//  4. Read 0x30000000 (unmapped) -> per_sel never asserts; done+err @T1, rdata=0.
//  5. PBC_TIMEOUT_EN, region 0 never acks -> per_sel=4'b0001 for 16 cycles; then done+err,
//     rdata=0. Without macro: still waiting after 100 cycles.
//  6. cpu_req held high for two back-to-back reads to regions 0 and 2; stray per_ack[3]
//     pulse during the first -> ignored; two done pulses separated by one IDLE cycle.

Source files
------------

// File: rtl/periph_bus_ctrl.sv
// Sequences single CPU load/store transactions onto a four-region peripheral bus.
// Define PBC_TIMEOUT_EN to abort accesses whose slave never acks within TIMEOUT_CYCLES.
module periph_bus_ctrl #(
  parameter logic [31:0] BASE0 = 32'h2000_0000,
  parameter logic [31:0] MASK0 = 32'hFFFF_0000,
  parameter logic [31:0] BASE1 = 32'h2001_0000,
  parameter logic [31:0] MASK1 = 32'hFFFF_0000,
  parameter logic [31:0] BASE2 = 32'h2002_0000,
  parameter logic [31:0] MASK2 = 32'hFFFF_0000,
  parameter logic [31:0] BASE3 = 32'h2003_0000,
  parameter logic [31:0] MASK3 = 32'hFFFF_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [63:0]   cpu_wdata,
  output logic [63:0]   cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_err,
  output logic [3:0]    per_sel,
  output logic          per_we,
  output logic [31:0]   per_addr,
  output logic [63:0]   per_wdata,
  input  logic [255:0]  per_rdata,
  input  logic [3:0]    per_ack
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  hit;
  logic        hit_any;
  logic [1:0]  hit_idx;
  logic        ack_sel;
  logic        tmo;
  logic [63:0] rd_sel;

  // The 5-bit timeout counter can only express limits up to 32 cycles.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32) begin : g_bad_timeout
    $error("periph_bus_ctrl: TIMEOUT_CYCLES must be in 1..32");
  end

  always_comb begin
    hit[0]  = ((cpu_addr & MASK0) == BASE0);
    hit[1]  = ((cpu_addr & MASK1) == BASE1);
    hit[2]  = ((cpu_addr & MASK2) == BASE2);
    hit[3]  = ((cpu_addr & MASK3) == BASE3);
    hit_any = |hit;
    // Later assignments override earlier ones, so the lowest hitting index wins.
    hit_idx = 2'd3;
    if (hit[2]) hit_idx = 2'd2;
    if (hit[1]) hit_idx = 2'd1;
    if (hit[0]) hit_idx = 2'd0;
  end

  assign ack_sel = |(per_ack & per_sel);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < 4; i++) begin
      if (per_sel[i]) rd_sel = per_rdata[64*i +: 64];
    end
  end

`ifdef PBC_TIMEOUT_EN
  logic [4:0] tcnt;

  // Held at zero outside ACCESS, so every access starts counting from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              tcnt <= '0;
    else if (state != ACCESS)  tcnt <= '0;
    else if (!ack_sel)         tcnt <= tcnt + 5'd1;
  end

  assign tmo = (tcnt == 5'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req) state_nxt = hit_any ? ACCESS : RESP;
      ACCESS:  if (ack_sel || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response outputs are registered alongside the transition into RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_sel   <= '0;
      per_we    <= 1'b0;
      per_addr  <= '0;
      per_wdata <= '0;
      cpu_rdata <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req && hit_any) begin
            per_sel   <= 4'b0001 << hit_idx;
            per_we    <= cpu_we;
            per_addr  <= cpu_addr;
            per_wdata <= cpu_wdata;
          end else if (cpu_req) begin
            cpu_done  <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
          end
        end
        ACCESS: begin
          if (ack_sel) begin
            per_sel   <= '0;
            cpu_done  <= 1'b1;
            cpu_rdata <= per_we ? 64'd0 : rd_sel;
          end else if (tmo) begin
            per_sel   <= '0;
            cpu_done  <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Self-checking bench for periph_bus_ctrl: vector table, corner-case sequences and
// randomized transactions against a region-decode reference model.
module tb_periph_bus_ctrl;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [63:0]   cpu_wdata;
  logic [63:0]   cpu_rdata;
  logic          cpu_done;
  logic          cpu_err;
  logic [3:0]    per_sel;
  logic          per_we;
  logic [31:0]   per_addr;
  logic [63:0]   per_wdata;
  logic [255:0]  per_rdata;
  logic [3:0]    per_ack;

  int pass_cnt  = 0;
  int total_cnt = 0;

  localparam logic [31:0] BASES [4] = '{32'h2000_0000, 32'h2001_0000, 32'h2002_0000, 32'h2003_0000};
  localparam logic [31:0] MASKS [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  periph_bus_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_done(cpu_done), .cpu_err(cpu_err), .per_sel(per_sel), .per_we(per_we),
    .per_addr(per_addr), .per_wdata(per_wdata), .per_rdata(per_rdata), .per_ack(per_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
    int          delay;
    int          slot;
    logic [63:0] slot_data;
    logic [3:0]  exp_sel;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference decode: first region whose masked address equals its base, or -1.
  function automatic int ref_region(input logic [31:0] addr);
    for (int i = 0; i < 4; i++) begin
      if ((addr & MASKS[i]) == BASES[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [255:0] background_bus();
    logic [255:0] b;
    for (int j = 0; j < 4; j++) b[64*j +: 64] = 64'hB0B0_0000_0000_0000 | 64'(j);
    return b;
  endfunction

  // One complete transaction with the bench acting as slave; exp_sel==0 means unmapped.
  task automatic apply_stimulus(input string tag, input logic we, input logic [31:0] addr,
                                input logic [63:0] wdata, input int delay,
                                input logic [255:0] bus, input logic [3:0] exp_sel,
                                input logic exp_err, input logic [63:0] exp_rdata,
                                input logic stray_en);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    per_rdata = bus;
    per_ack   = 4'b0000;
    step();
    cpu_req = 1'b0;
    if (exp_sel == 4'b0000) begin
      check_output({tag, "_nosel"}, 64'(per_sel), 64'(4'b0000));
      check_output({tag, "_done"}, 64'(cpu_done), 64'(1'b1));
      check_output({tag, "_err"}, 64'(cpu_err), 64'(exp_err));
      check_output({tag, "_rdata"}, cpu_rdata, exp_rdata);
    end else begin
      for (int c = 0; c <= delay; c++) begin
        check_output($sformatf("%s_sel%0d", tag, c), 64'(per_sel), 64'(exp_sel));
        check_output($sformatf("%s_busy%0d", tag, c), 64'(cpu_done), 64'(1'b0));
        if (c == 0) begin
          check_output({tag, "_we"}, 64'(per_we), 64'(we));
          check_output({tag, "_addr"}, 64'(per_addr), 64'(addr));
          check_output({tag, "_wdata"}, per_wdata, wdata);
        end
        per_ack = (c == delay) ? exp_sel : 4'b0000;
        if (stray_en) per_ack = per_ack | (4'($urandom) & ~exp_sel);
        step();
      end
      per_ack = 4'b0000;
      check_output({tag, "_done"}, 64'(cpu_done), 64'(1'b1));
      check_output({tag, "_err"}, 64'(cpu_err), 64'(exp_err));
      check_output({tag, "_rdata"}, cpu_rdata, exp_rdata);
      check_output({tag, "_seldrop"}, 64'(per_sel), 64'(4'b0000));
    end
    step();
    check_output({tag, "_donelow"}, 64'(cpu_done), 64'(1'b0));
    check_output({tag, "_errlow"}, 64'(cpu_err), 64'(1'b0));
    check_output({tag, "_rdhold"}, cpu_rdata, exp_rdata);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [255:0] bus;
    logic [63:0]  words [4];
    logic [31:0]  addr;
    logic [63:0]  wdata;
    logic         we;
    logic [3:0]   exp_sel;
    logic         exp_err;
    logic [63:0]  exp_rdata;
    int           region;
    int           kind;

    vecs[0] = '{1'b0, 32'h2001_0008, 64'h0,  0, 1, 64'hDEADBEEF_00000001, 4'b0010, 1'b0, 64'hDEADBEEF_00000001};
    vecs[1] = '{1'b1, 32'h2003_0000, 64'h55, 3, 3, 64'h1234,              4'b1000, 1'b0, 64'h0};
    vecs[2] = '{1'b0, 32'h3000_0000, 64'h0,  0, 0, 64'h7777,              4'b0000, 1'b1, 64'h0};
    vecs[3] = '{1'b0, 32'h2000_0000, 64'h0,  1, 0, 64'hA5A5_A5A5_A5A5_A5A5, 4'b0001, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5};
    vecs[4] = '{1'b0, 32'h2003_FFFF, 64'h0,  2, 3, 64'h0123_4567_89AB_CDEF, 4'b1000, 1'b0, 64'h0123_4567_89AB_CDEF};
    vecs[5] = '{1'b0, 32'h2004_0000, 64'h0,  0, 0, 64'h8888,              4'b0000, 1'b1, 64'h0};
    vecs[6] = '{1'b1, 32'h2001_0010, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'h9999, 4'b0010, 1'b0, 64'h0};
    vecs[7] = '{1'b0, 32'h1FFF_FFFC, 64'h0,  0, 0, 64'h6666,              4'b0000, 1'b1, 64'h0};
    vecs[8] = '{1'b0, 32'h2002_FFF8, 64'h0,  0, 2, 64'hCAFE_F00D_0000_0002, 4'b0100, 1'b0, 64'hCAFE_F00D_0000_0002};

    reset_n   = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    per_rdata = '0;
    per_ack   = '0;
    repeat (3) step();
    check_output("reset_outputs", 64'({per_sel, per_we, cpu_done, cpu_err, |per_addr, |per_wdata, |cpu_rdata}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_output($sformatf("idle_zero%0d", i),
                   64'({per_sel, per_we, cpu_done, cpu_err, |per_addr, |per_wdata, |cpu_rdata}), 64'd0);
    end

    for (int v = 0; v < 9; v++) begin
      bus = background_bus();
      bus[64*vecs[v].slot +: 64] = vecs[v].slot_data;
      apply_stimulus($sformatf("tbl%0d", v), vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].delay,
                     bus, vecs[v].exp_sel, vecs[v].exp_err, vecs[v].exp_rdata, 1'b0);
    end

    // Back-to-back reads with req held high and a stray ack from an unselected region.
    bus = background_bus();
    bus[63:0]    = 64'h0000_0000_1111_00A0;
    bus[191:128] = 64'h0000_0000_2222_00C2;
    per_rdata = bus;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h2000_0040;
    step();
    check_output("b2b_sel0", 64'(per_sel), 64'(4'b0001));
    per_ack = 4'b1000;
    step();
    check_output("b2b_stray_sel", 64'(per_sel), 64'(4'b0001));
    check_output("b2b_stray_done", 64'(cpu_done), 64'(1'b0));
    per_ack = 4'b0001;
    step();
    per_ack = 4'b0000;
    check_output("b2b_done1", 64'(cpu_done), 64'(1'b1));
    check_output("b2b_rdata1", cpu_rdata, 64'h0000_0000_1111_00A0);
    check_output("b2b_err1", 64'(cpu_err), 64'(1'b0));
    cpu_addr = 32'h2002_0040;
    step();
    check_output("b2b_gap_done", 64'(cpu_done), 64'(1'b0));
    check_output("b2b_gap_sel", 64'(per_sel), 64'(4'b0000));
    step();
    check_output("b2b_sel2", 64'(per_sel), 64'(4'b0100));
    cpu_req = 1'b0;
    per_ack = 4'b0100;
    step();
    per_ack = 4'b0000;
    check_output("b2b_done2", 64'(cpu_done), 64'(1'b1));
    check_output("b2b_rdata2", cpu_rdata, 64'h0000_0000_2222_00C2);
    step();
    check_output("b2b_end_done", 64'(cpu_done), 64'(1'b0));

    // Asynchronous reset in the middle of an access; a late ack must be ignored.
    cpu_req  = 1'b1;
    cpu_addr = 32'h2002_0004;
    step();
    cpu_req = 1'b0;
    check_output("midrst_sel_before", 64'(per_sel), 64'(4'b0100));
    #2;
    reset_n = 1'b0;
    #1;
    check_output("midrst_sel_async", 64'(per_sel), 64'(4'b0000));
    check_output("midrst_addr", 64'(per_addr), 64'd0);
    check_output("midrst_rdata", cpu_rdata, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    per_ack = 4'b0100;
    step();
    per_ack = 4'b0000;
    step();
    check_output("midrst_no_done", 64'(cpu_done), 64'(1'b0));
    check_output("midrst_idle_sel", 64'(per_sel), 64'(4'b0000));

    bus = background_bus();
    bus[63:0] = 64'h0000_0000_0000_0ACC;
    per_rdata = bus;
    cpu_we    = 1'b0;
    cpu_addr  = 32'h2000_0010;
    cpu_req   = 1'b1;
    step();
    cpu_req = 1'b0;
`ifdef PBC_TIMEOUT_EN
    for (int c = 1; c <= 16; c++) begin
      check_output($sformatf("tmo_sel%0d", c), 64'(per_sel), 64'(4'b0001));
      check_output($sformatf("tmo_busy%0d", c), 64'(cpu_done), 64'(1'b0));
      step();
    end
    check_output("tmo_done", 64'(cpu_done), 64'(1'b1));
    check_output("tmo_err", 64'(cpu_err), 64'(1'b1));
    check_output("tmo_rdata", cpu_rdata, 64'd0);
    check_output("tmo_seldrop", 64'(per_sel), 64'(4'b0000));
    step();
    check_output("tmo_donelow", 64'(cpu_done), 64'(1'b0));
    cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
    for (int c = 1; c < 16; c++) step();
    check_output("tmo_edge_sel", 64'(per_sel), 64'(4'b0001));
    per_ack = 4'b0001;
    step();
    per_ack = 4'b0000;
    check_output("tmo_edge_done", 64'(cpu_done), 64'(1'b1));
    check_output("tmo_edge_err", 64'(cpu_err), 64'(1'b0));
    check_output("tmo_edge_rdata", cpu_rdata, 64'h0000_0000_0000_0ACC);
    step();
`else
    for (int c = 1; c <= 100; c++) begin
      if (per_sel !== 4'b0001 || cpu_done !== 1'b0) begin
        check_output($sformatf("nowait_sel%0d", c), 64'({per_sel, cpu_done}), 64'({4'b0001, 1'b0}));
      end
      step();
    end
    check_output("nowait_sel_final", 64'(per_sel), 64'(4'b0001));
    check_output("nowait_busy_final", 64'(cpu_done), 64'(1'b0));
    per_ack = 4'b0001;
    step();
    per_ack = 4'b0000;
    check_output("nowait_done", 64'(cpu_done), 64'(1'b1));
    check_output("nowait_err", 64'(cpu_err), 64'(1'b0));
    check_output("nowait_rdata", cpu_rdata, 64'h0000_0000_0000_0ACC);
    step();
`endif

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      if (kind < 4) addr = BASES[kind] | {16'h0000, 16'($urandom)};
      else          addr = $urandom;
      we    = 1'($urandom);
      wdata = {$urandom, $urandom};
      for (int j = 0; j < 4; j++) words[j] = {$urandom, $urandom};
      bus    = {words[3], words[2], words[1], words[0]};
      region = ref_region(addr);
      if (region < 0) begin
        exp_sel   = 4'b0000;
        exp_err   = 1'b1;
        exp_rdata = 64'd0;
      end else begin
        exp_sel   = 4'(1 << region);
        exp_err   = 1'b0;
        exp_rdata = we ? 64'd0 : words[region];
      end
      apply_stimulus($sformatf("rnd%0d", n), we, addr, wdata, $urandom_range(0, 4),
                     bus, exp_sel, exp_err, exp_rdata, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
